uart_rx: RTL

- 8N1-style UART receiver; companion of the team's fractional-N baud tick generator `baud_gen`.
- Synchronises `rxd`, detects the start edge, and runs the baud generator in aligned mode so ticks land at mid-bit.
- Samples the frame and presents each byte through a one-entry valid/ready holding register to the downstream (CSR or FIFO).

---
 rtl/uart_pkg.sv | 19 +
 rtl/baud_gen.sv | 47 ++++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice: FSM state encoding and default line timing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } rx_state_t;

    localparam int DEF_CLK_FREQ_HZ = 25_000_000;
    localparam int DEF_BAUD_RATE   = 115_200;

    // Whole clocks per bit at the default rates; handy for stimulus generation.
    localparam int BIT_CLKS = DEF_CLK_FREQ_HZ / DEF_BAUD_RATE;

endpackage : uart_pkg

// File: rtl/baud_gen.sv
// Fractional-N baud tick generator. The phase accumulator advances by BAUD_RATE each clock
// and wraps at CLK_FREQ_HZ; align preloads half a period so the first tick lands mid-bit.
module baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = DEF_BAUD_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic align,
    output logic tick
);

    localparam logic [31:0] INC  = 32'(BAUD_RATE);
    localparam logic [31:0] MOD  = 32'(CLK_FREQ_HZ);
    localparam logic [31:0] HALF = 32'(CLK_FREQ_HZ / 2);

    logic [31:0] acc_r;
    logic [31:0] acc_next_s;
    logic        tick_r;

    assign acc_next_s = acc_r + INC;
    assign tick       = tick_r;

    // Phase accumulator with registered overflow tick; align wins over a disabled enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= 32'd0;
            tick_r <= 1'b0;
        end else if (align) begin
            acc_r  <= HALF;
            tick_r <= 1'b0;
        end else if (!en) begin
            acc_r  <= 32'd0;
            tick_r <= 1'b0;
        end else if (acc_next_s >= MOD) begin
            acc_r  <= acc_next_s - MOD;
            tick_r <= 1'b1;
        end else begin
            acc_r  <= acc_next_s;
            tick_r <= 1'b0;
        end
    end

endmodule : baud_gen

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to insert a parity bit between the data bits and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = DEF_BAUD_RATE,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    rx_state_t            state_r;
    logic                 rx_meta_r;
    logic                 rx_sync_r;
    logic                 rx_prev_r;
    logic                 start_edge_s;
    logic                 tick_s;
    logic                 en_s;
    logic                 align_s;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 valid_r;
    logic                 ferr_r;
    logic                 perr_r;
    logic                 ovr_r;
    logic                 busy_r;
    logic                 parity_err_s;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idle line is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign start_edge_s = rx_prev_r & ~rx_sync_r;
    assign en_s         = (state_r != IDLE);
    assign align_s      = (state_r == IDLE) & start_edge_s;

    baud_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD_RATE   (BAUD_RATE)
    ) u_baud_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_s),
        .align (align_s),
        .tick  (tick_s)
    );

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
    logic par_bit_r;

    // Received parity differs from XOR of the data bits (inverted for odd sense).
    assign parity_err_s = par_bit_r ^ (^shift_r) ^ PAR_SENSE;

    // Parity bit is captured on its own mid-bit tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit_r <= 1'b0;
        end else if ((state_r == PARITY) && tick_s) begin
            par_bit_r <= rx_sync_r;
        end else begin
            par_bit_r <= par_bit_r;
        end
    end
`else
    logic unused_s;

    assign parity_err_s = 1'b0;
    assign unused_s     = (PARITY_ODD != 0);
`endif

    // Receive FSM with the holding register; a completed frame overrides the same-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= '0;
            shift_r   <= '0;
            rx_data_r <= '0;
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
            perr_r    <= 1'b0;
            ovr_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            ovr_r <= 1'b0;
            if (valid_r && rx_ready) begin
                valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (start_edge_s) begin
                        state_r   <= START;
                        bit_cnt_r <= '0;
                        busy_r    <= 1'b1;
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (rx_sync_r) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        shift_r   <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        if (bit_cnt_r == CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_s) begin
                        state_r <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick_s) begin
                        if (!valid_r || rx_ready) begin
                            rx_data_r <= shift_r;
                            ferr_r    <= ~rx_sync_r;
                            perr_r    <= parity_err_s;
                            valid_r   <= 1'b1;
                        end else begin
                            ovr_r <= 1'b1;
                        end
                        // A low stop bit may be a break; wait for the line to recover.
                        if (rx_sync_r) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= BREAK_WAIT;
                        end
                    end
                end
                BREAK_WAIT: begin
                    if (rx_sync_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data       = rx_data_r;
    assign rx_valid      = valid_r;
    assign rx_frame_err  = ferr_r;
    assign rx_parity_err = perr_r;
    assign rx_overrun    = ovr_r;
    assign busy          = busy_r;

endmodule : uart_rx
